// File: rtl/spi_host.sv
// spi_host: SPI mode-0 main for the bring-up harness.
// Sends one instruction word {read, code, start_address, num_transactions}
// and then exactly num_transactions data words. Write data comes from a
// valid/ready stream; read data is returned on a valid/ready stream.
// Optional feature macro: SPI_HOST_DONE_PULSE_EN adds a one-cycle 'done'
// output in the first IDLE cycle after a frame completes.
module spi_host #(
  parameter int unsigned MESSAGE_BIT_WIDTH       = 32,
  parameter int unsigned CODE_BIT_WIDTH          = 4,
  parameter int unsigned START_ADDRESS_BIT_WIDTH = 16,
  parameter int unsigned CLK_DIV                 = 4,
  localparam int unsigned NUM_TRANSACTIONS_BIT_WIDTH =
    MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1
) (
  input  logic                                  CLK,
  input  logic                                  RST_sync_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_read,
  input  logic [CODE_BIT_WIDTH-1:0]             cmd_code,
  input  logic [START_ADDRESS_BIT_WIDTH-1:0]    cmd_start_address,
  input  logic [NUM_TRANSACTIONS_BIT_WIDTH-1:0] cmd_num_transactions,
  input  logic [MESSAGE_BIT_WIDTH-1:0]          wr_data,
  input  logic                                  wr_data_valid,
  output logic                                  wr_data_ready,
  output logic [MESSAGE_BIT_WIDTH-1:0]          rd_data,
  output logic                                  rd_data_valid,
  input  logic                                  rd_data_ready,
  output logic                                  busy,
`ifdef SPI_HOST_DONE_PULSE_EN
  output logic                                  done,
`endif
  output logic                                  SCK,
  output logic                                  MOSI,
  input  logic                                  MISO
);

  localparam int unsigned MW    = MESSAGE_BIT_WIDTH;
  localparam int unsigned NW    = NUM_TRANSACTIONS_BIT_WIDTH;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (MW > 1) ? $clog2(MW) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MW - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SHIFT_LOW  = 2'd1,
    S_SHIFT_HIGH = 2'd2,
    S_GAP        = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  // Number of data words started so far; 0 while the instruction shifts.
  logic [NW-1:0]     word_q, word_d;
  logic [NW-1:0]     num_q, num_d;
  logic              read_q, read_d;
  logic [MW-1:0]     tx_q, tx_d;
  logic [MW-1:0]     rx_q, rx_d;
  logic [MW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
`ifdef SPI_HOST_DONE_PULSE_EN
  logic              done_q, done_d;
`endif

  logic              words_left_c;
  logic              start_word_c;

  assign words_left_c = (word_q != num_q);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    word_d       = word_q;
    num_d        = num_q;
    read_d       = read_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    start_word_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_SHIFT_LOW;
          div_d   = '0;
          bit_d   = '0;
          word_d  = '0;
          num_d   = cmd_num_transactions;
          read_d  = cmd_read;
          tx_d    = {cmd_read, cmd_code, cmd_start_address, cmd_num_transactions};
        end
      end

      S_SHIFT_LOW: begin
        if (div_q == DIV_LAST) begin
          // Rising SCK: capture MISO, LSB in.
          state_d = S_SHIFT_HIGH;
          div_d   = '0;
          rx_d    = {rx_q[MW-2:0], MISO};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_SHIFT_HIGH: begin
        if (div_q == DIV_LAST) begin
          // Falling SCK: advance the transmit word.
          div_d = '0;
          tx_d  = {tx_q[MW-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (read_q && (word_q != '0)) begin
              state_d    = S_GAP;
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
            end else if (words_left_c) begin
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = S_SHIFT_LOW;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (read_q) begin
          if (rd_valid_q) begin
            if (rd_data_ready) begin
              rd_valid_d = 1'b0;
              if (words_left_c) begin
                start_word_c = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            // Gap after the instruction word: its rx word is discarded.
            start_word_c = 1'b1;
          end
        end else if (wr_data_valid && wr_ready_q) begin
          start_word_c = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Launch the next data word out of GAP.
    if (start_word_c) begin
      state_d = S_SHIFT_LOW;
      div_d   = '0;
      bit_d   = '0;
      word_d  = word_q + NW'(1);
      tx_d    = read_q ? '0 : wr_data;
    end

    wr_ready_d  = (state_d == S_GAP) && !read_d && (word_d != num_d);
    sck_d       = (state_d == S_SHIFT_HIGH);
    mosi_d      = ((state_d == S_SHIFT_LOW) || (state_d == S_SHIFT_HIGH)) ? tx_d[MW-1] : 1'b0;
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
`ifdef SPI_HOST_DONE_PULSE_EN
    done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_sync_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      num_q       <= '0;
      read_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef SPI_HOST_DONE_PULSE_EN
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      num_q       <= num_d;
      read_q      <= read_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef SPI_HOST_DONE_PULSE_EN
      done_q      <= done_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign wr_data_ready = wr_ready_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign busy          = busy_q;
  assign SCK           = sck_q;
  assign MOSI          = mosi_q;
`ifdef SPI_HOST_DONE_PULSE_EN
  assign done          = done_q;
`endif

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed bench for spi_host with CLK_DIV=2. Captures MOSI
// words on SCK rising edges and serves MISO words from a table.
`timescale 1ns/1ps
module tb_spi_host;

  localparam int unsigned DIV = 2;

  logic        CLK = 1'b0;
  logic        RST_sync_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [3:0]  cmd_code;
  logic [15:0] cmd_start_address;
  logic [10:0] cmd_num_transactions;
  logic [31:0] wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready;
  logic        busy;
`ifdef SPI_HOST_DONE_PULSE_EN
  logic        done;
`endif
  logic        SCK;
  logic        MOSI;
  logic        MISO;

  spi_host #(
    .MESSAGE_BIT_WIDTH       (32),
    .CODE_BIT_WIDTH          (4),
    .START_ADDRESS_BIT_WIDTH (16),
    .CLK_DIV                 (DIV)
  ) dut (
    .CLK                  (CLK),
    .RST_sync_n           (RST_sync_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_read             (cmd_read),
    .cmd_code             (cmd_code),
    .cmd_start_address    (cmd_start_address),
    .cmd_num_transactions (cmd_num_transactions),
    .wr_data              (wr_data),
    .wr_data_valid        (wr_data_valid),
    .wr_data_ready        (wr_data_ready),
    .rd_data              (rd_data),
    .rd_data_valid        (rd_data_valid),
    .rd_data_ready        (rd_data_ready),
    .busy                 (busy),
`ifdef SPI_HOST_DONE_PULSE_EN
    .done                 (done),
`endif
    .SCK                  (SCK),
    .MOSI                 (MOSI),
    .MISO                 (MISO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int          sck_edges = 0;
  int          base = 0;
  logic [31:0] shreg = '0;
  logic [31:0] cap [0:7];
  logic [31:0] miso_words [0:7];
  logic [31:0] wr_words [0:7];
  logic [31:0] rd_got [0:7];

  // Per-frame observations filled by do_frame.
  int f_cycles, f_first_rise, f_edges, f_wr_seen, f_rd_seen;
  int f_stall_bad, f_proto_bad, f_done, f_nrd, f_stall_left;
  bit f_timeout;

  // Client-side MOSI capture on SCK rising edges.
  always @(posedge SCK) begin
    shreg <= {shreg[30:0], MOSI};
    if ((((sck_edges - base) % 32) == 31) && (((sck_edges - base) / 32) < 8))
      cap[(sck_edges - base) / 32] <= {shreg[30:0], MOSI};
    sck_edges <= sck_edges + 1;
  end

  // Client-side MISO: bit k of the frame comes from miso_words, MSB first.
  int          miso_rel;
  logic [31:0] miso_cur;
  assign miso_rel = sck_edges - base;
  assign miso_cur = ((miso_rel / 32) < 8) ? miso_words[miso_rel / 32] : 32'h0;
  assign MISO     = miso_cur[5'(31 - (miso_rel % 32))];

  task automatic do_frame(input bit rd, input logic [3:0] code, input logic [15:0] addr,
                          input logic [10:0] n, input int stall_word, input int stall_cyc);
    int wi, ri, sc;
    bit started, acc_cmd, acc_wr, acc_rd, stalled_w, stalled_r, seen_stall;
    logic [31:0] stall_data;
    base = sck_edges;
    f_first_rise = -1; f_wr_seen = 0; f_rd_seen = 0; f_stall_bad = 0;
    f_proto_bad = 0; f_done = 0; f_nrd = 0; f_timeout = 1'b1;
    f_stall_left = stall_cyc;
    wi = 0; ri = 0; sc = 0; started = 1'b0; seen_stall = 1'b0; stall_data = '0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_code = code;
    cmd_start_address = addr; cmd_num_transactions = n;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      stalled_w     = !rd && (wi == stall_word) && (f_stall_left > 0);
      stalled_r     = rd && (ri == stall_word) && (f_stall_left > 0);
      wr_data_valid = !rd && (wi < int'(n)) && !stalled_w;
      wr_data       = (wi < 8) ? wr_words[wi] : 32'h0;
      rd_data_ready = !stalled_r;
      if (stalled_w && wr_data_ready) begin
        f_stall_left--;
        if (SCK !== 1'b0) f_stall_bad++;
      end
      if (stalled_r && rd_data_valid) begin
        if (!seen_stall) stall_data = rd_data;
        seen_stall = 1'b1;
        f_stall_left--;
        if (SCK !== 1'b0 || rd_data !== stall_data) f_stall_bad++;
      end else if (stalled_r && seen_stall) begin
        f_stall_bad++;
      end
      if (wr_data_ready) f_wr_seen++;
      if (rd_data_valid) f_rd_seen++;
      acc_cmd = cmd_valid && cmd_ready;
      acc_wr  = wr_data_valid && wr_data_ready;
      acc_rd  = rd_data_ready && rd_data_valid;
      if (acc_rd) begin
        if (ri < 8) rd_got[ri] = rd_data;
        ri++;
      end
      @(posedge CLK); #1;
`ifdef SPI_HOST_DONE_PULSE_EN
      if (done === 1'b1) f_done++;
`endif
      if (acc_cmd) begin
        cmd_valid = 1'b0;
        started   = 1'b1;
        sc        = 1;
      end else if (started) begin
        sc++;
      end
      if (acc_wr) wi++;
      if (started && SCK === 1'b1 && f_first_rise < 0) f_first_rise = sc;
      if (started && busy === 1'b1 && cmd_ready === 1'b1) f_proto_bad++;
      if (busy === 1'b0 && SCK !== 1'b0) f_proto_bad++;
      if (started && busy === 1'b0) begin
        f_timeout = 1'b0;
        break;
      end
    end
    wr_data_valid = 1'b0;
    rd_data_ready = 1'b0;
    f_cycles = sc;
    f_nrd    = ri;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
`ifdef SPI_HOST_DONE_PULSE_EN
      if (done === 1'b1) f_done++;
`endif
    end
    f_edges = sck_edges - base;
    if (f_timeout) begin
      errors++;
      $display("FAIL frame_timeout: busy never fell, cycles %0d", sc);
    end
    checks++;
  endtask

  task automatic test_reset();
    RST_sync_n = 1'b0;
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_code = '0; cmd_start_address = '0;
    cmd_num_transactions = '0; wr_data = '0; wr_data_valid = 1'b0; rd_data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin miso_words[i] = '0; wr_words[i] = '0; end
    repeat (3) @(posedge CLK);
    #1;
    if ({SCK, MOSI, wr_data_ready, rd_data_valid, busy, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000001",
               {SCK, MOSI, wr_data_ready, rd_data_valid, busy, cmd_ready});
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
    end
    checks++;
    RST_sync_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: cmd_ready %b busy %b expected 1 0", cmd_ready, busy);
    end
    checks++;
  endtask

  task automatic test_write_single();
    wr_words[0] = 32'hDEADBEEF;
    do_frame(1'b0, 4'h0, 16'h0004, 11'd1, -1, 0);
    if (cap[0] !== 32'h00002001) begin
      errors++; $display("FAIL wr1_instr: got %h expected 00002001", cap[0]);
    end
    checks++;
    if (cap[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr1_data: got %h expected DEADBEEF", cap[1]);
    end
    checks++;
    if (f_edges !== 64) begin
      errors++; $display("FAIL wr1_edges: got %0d expected 64", f_edges);
    end
    checks++;
    if (f_first_rise !== DIV + 1) begin
      errors++; $display("FAIL wr1_first_rise: got %0d expected %0d", f_first_rise, DIV + 1);
    end
    checks++;
    if (busy !== 1'b0 || f_proto_bad !== 0 || f_rd_seen !== 0) begin
      errors++; $display("FAIL wr1_protocol: busy %b proto %0d rd_valid %0d expected 0 0 0",
                         busy, f_proto_bad, f_rd_seen);
    end
    checks++;
`ifdef SPI_HOST_DONE_PULSE_EN
    if (f_done !== 1) begin
      errors++; $display("FAIL wr1_done: got %0d pulses expected 1", f_done);
    end
    checks++;
`endif
  endtask

  task automatic test_read_two();
    miso_words[0] = 32'hA5A5A5A5;
    miso_words[1] = 32'h11111111;
    miso_words[2] = 32'h22222222;
    do_frame(1'b1, 4'h3, 16'h0010, 11'd2, -1, 0);
    if (cap[0] !== 32'h98008002) begin
      errors++; $display("FAIL rd_instr: got %h expected 98008002", cap[0]);
    end
    checks++;
    if (f_nrd !== 2 || rd_got[0] !== 32'h11111111 || rd_got[1] !== 32'h22222222) begin
      errors++; $display("FAIL rd_words: got %0d words %h %h expected 2 11111111 22222222",
                         f_nrd, rd_got[0], rd_got[1]);
    end
    checks++;
    if (f_edges !== 96 || cap[1] !== 32'h0 || cap[2] !== 32'h0) begin
      errors++; $display("FAIL rd_edges_mosi: edges %0d mosi %h %h expected 96 0 0",
                         f_edges, cap[1], cap[2]);
    end
    checks++;
  endtask

  task automatic test_read_stall();
    miso_words[0] = 32'h0F0F0F0F;
    miso_words[1] = 32'h12345678;
    miso_words[2] = 32'hCAFEF00D;
    do_frame(1'b1, 4'h3, 16'h0010, 11'd2, 0, 50);
    if (f_stall_left !== 0 || f_stall_bad !== 0) begin
      errors++; $display("FAIL rd_stall: left %0d violations %0d expected 0 0", f_stall_left, f_stall_bad);
    end
    checks++;
    if (f_nrd !== 2 || rd_got[0] !== 32'h12345678 || rd_got[1] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rd_stall_words: got %0d words %h %h expected 2 12345678 CAFEF00D",
                         f_nrd, rd_got[0], rd_got[1]);
    end
    checks++;
    if (f_edges !== 96) begin
      errors++; $display("FAIL rd_stall_edges: got %0d expected 96", f_edges);
    end
    checks++;
  endtask

  task automatic test_write_stall();
    wr_words[0] = 32'h01234567;
    wr_words[1] = 32'h89ABCDEF;
    wr_words[2] = 32'h5A5AA5A5;
    do_frame(1'b0, 4'h5, 16'h0ABC, 11'd3, 1, 20);
    if (f_stall_left !== 0 || f_stall_bad !== 0) begin
      errors++; $display("FAIL wr_stall: left %0d violations %0d expected 0 0", f_stall_left, f_stall_bad);
    end
    checks++;
    if (f_edges !== 128) begin
      errors++; $display("FAIL wr_stall_edges: got %0d expected 128", f_edges);
    end
    checks++;
    if (cap[0] !== 32'h2855E003) begin
      errors++; $display("FAIL wr_stall_instr: got %h expected 2855E003", cap[0]);
    end
    checks++;
    if (cap[1] !== 32'h01234567 || cap[2] !== 32'h89ABCDEF || cap[3] !== 32'h5A5AA5A5) begin
      errors++; $display("FAIL wr_stall_data: got %h %h %h expected 01234567 89ABCDEF 5A5AA5A5",
                         cap[1], cap[2], cap[3]);
    end
    checks++;
  endtask

  task automatic test_zero_count();
    do_frame(1'b0, 4'hF, 16'hFFFF, 11'd0, -1, 0);
    if (cap[0] !== 32'h7FFFF800 || f_edges !== 32) begin
      errors++; $display("FAIL n0_word: got %h edges %0d expected 7FFFF800 32", cap[0], f_edges);
    end
    checks++;
    if (f_wr_seen !== 0 || f_rd_seen !== 0) begin
      errors++; $display("FAIL n0_streams: wr_ready %0d rd_valid %0d expected 0 0", f_wr_seen, f_rd_seen);
    end
    checks++;
    if (f_cycles !== 1 + 2 * DIV * 32) begin
      errors++; $display("FAIL n0_length: got %0d cycles expected %0d", f_cycles, 1 + 2 * DIV * 32);
    end
    checks++;
`ifdef SPI_HOST_DONE_PULSE_EN
    if (f_done !== 1) begin
      errors++; $display("FAIL n0_done: got %0d pulses expected 1", f_done);
    end
    checks++;
`endif
  endtask

  task automatic test_reset_abort();
    int k;
    int pulses;
    base = sck_edges;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_code = 4'h2;
    cmd_start_address = 16'h0100; cmd_num_transactions = 11'd2;
    wr_data = 32'hCAFEBABE; wr_data_valid = 1'b1; rd_data_ready = 1'b0;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!((sck_edges - base) >= 40 && SCK === 1'b1) && k < 5000) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 5000) begin
      errors++; $display("FAIL abort_reach: edges %0d expected at least 40", sck_edges - base);
    end
    checks++;
    RST_sync_n = 1'b0;
    @(posedge CLK); #1;
    if ({SCK, MOSI, cmd_ready, busy, wr_data_ready} !== 5'b00100) begin
      errors++; $display("FAIL abort_state: got %b expected 00100",
                         {SCK, MOSI, cmd_ready, busy, wr_data_ready});
    end
    checks++;
    RST_sync_n = 1'b1;
    wr_data_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef SPI_HOST_DONE_PULSE_EN
      if (done === 1'b1) pulses++;
`endif
      if (busy !== 1'b0 || SCK !== 1'b0) pulses++;
      @(posedge CLK); #1;
    end
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d done/busy/sck events expected 0", pulses);
    end
    checks++;
    miso_words[0] = 32'h0;
    do_frame(1'b1, 4'h1, 16'h0002, 11'd0, -1, 0);
    if (cap[0] !== 32'h88001000 || f_edges !== 32 || f_rd_seen !== 0) begin
      errors++; $display("FAIL abort_recover: got %h edges %0d rd_valid %0d expected 88001000 32 0",
                         cap[0], f_edges, f_rd_seen);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_two();
    test_read_stall();
    test_write_stall();
    test_zero_count();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
